// File: rtl/shop_pkg.sv
// shop_pkg: shared types and constants for the shop command controller.
//   state_t  - controller FSM states
//   cmd_t    - decoded command tokens
//   CMD_*    - packed-ASCII command strings (right-aligned, zero-padded)
//   RSP_*    - packed-ASCII response strings
//   PERM_*   - user permission encoding
package shop_pkg;

  localparam int unsigned STR_W = 72;
  typedef logic [STR_W-1:0] str_t;

  typedef enum logic [2:0] {
    S_CMD, S_USER, S_PASS, S_PERM, S_ITEM, S_QTY
  } state_t;

  typedef enum logic [2:0] {
    C_NONE, C_LOGOUT, C_LOGIN, C_ADDUSR, C_DELUSR, C_ADDITEM, C_DELITEM, C_BUY
  } cmd_t;

  localparam str_t CMD_LOGOUT  = str_t'("Logout");
  localparam str_t CMD_LOGIN   = str_t'("Login");
  localparam str_t CMD_ADDUSR  = str_t'("AddUsr");
  localparam str_t CMD_DELUSR  = str_t'("DelUsr");
  localparam str_t CMD_ADDITEM = str_t'("AddItem");
  localparam str_t CMD_DELITEM = str_t'("DelItem");
  localparam str_t CMD_BUY     = str_t'("Buy");

  localparam str_t RSP_CMD       = str_t'("Cmd?");
  localparam str_t RSP_USRNAME   = str_t'("Usrname?");
  localparam str_t RSP_PASSWD    = str_t'("Passwd?");
  localparam str_t RSP_PERM      = str_t'("Perm?");
  localparam str_t RSP_ITEM      = str_t'("Item?");
  localparam str_t RSP_QTY       = str_t'("Qty?");
  localparam str_t RSP_OK        = str_t'("OK");
  localparam str_t RSP_INVALCMD  = str_t'("InvalCmd");
  localparam str_t RSP_INVALPERM = str_t'("InvalPerm");
  localparam str_t RSP_USRUNKNWN = str_t'("UsrUnknwn");
  localparam str_t RSP_USRTAKEN  = str_t'("UsrTaken");
  localparam str_t RSP_FULL      = str_t'("Full");
  localparam str_t RSP_NODELADMN = str_t'("NoDelAdmn");
  localparam str_t RSP_BADPASS   = str_t'("BadPass");
  localparam str_t RSP_ITMUNKNWN = str_t'("ItmUnknwn");
  localparam str_t RSP_NOSTOCK   = str_t'("NoStock");

  localparam str_t TOK_PERM_ADMIN = str_t'("A");

  localparam logic PERM_BUYER = 1'b0;
  localparam logic PERM_ADMIN = 1'b1;

  function automatic cmd_t decode_cmd(input str_t tok);
    cmd_t c;
    c = C_NONE;
    if (tok == CMD_LOGOUT)  c = C_LOGOUT;
    if (tok == CMD_LOGIN)   c = C_LOGIN;
    if (tok == CMD_ADDUSR)  c = C_ADDUSR;
    if (tok == CMD_DELUSR)  c = C_DELUSR;
    if (tok == CMD_ADDITEM) c = C_ADDITEM;
    if (tok == CMD_DELITEM) c = C_DELITEM;
    if (tok == CMD_BUY)     c = C_BUY;
    return c;
  endfunction

endpackage

// File: rtl/shop_if.sv
// shop_if: token/response bus between the token front end and shop_ctrl.
//   i_rdy/i_tok            - token valid and token (front end -> controller)
//   o_msg/o_msg_vld        - response string and its one-cycle qualifier
//   o_user/o_logged_in     - session status
// modport master: front end side; modport slave: controller side.
interface shop_if
  import shop_pkg::*;
#(
  parameter int unsigned TOK_W  = STR_W,
  parameter int unsigned USER_W = 2
);
  logic              i_rdy;
  logic [TOK_W-1:0]  i_tok;
  logic [TOK_W-1:0]  o_msg;
  logic              o_msg_vld;
  logic [USER_W-1:0] o_user;
  logic              o_logged_in;

  modport master (output i_rdy, i_tok, input o_msg, o_msg_vld, o_user, o_logged_in);
  modport slave  (input i_rdy, i_tok, output o_msg, o_msg_vld, o_user, o_logged_in);
endinterface

// File: rtl/shop_table.sv
// shop_table: small associative table of {valid, key, data} slots.
//   i_key               - lookup key; o_hit/o_hit_idx give the lowest matching slot
//   o_free_idx/o_full   - lowest empty slot and all-slots-used flag
//   o_data              - data of every slot (read by index in the parent)
//   i_wr/i_wr_*         - synchronous slot write (sets valid)
//   i_clr/i_clr_idx     - synchronous slot free
// Reset empties the table, optionally preloading slot 0.
module shop_table #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned KEY_W    = 72,
  parameter int unsigned DATA_W   = 8,
  parameter bit          PRELOAD  = 1'b0,
  parameter logic [KEY_W-1:0]  PRE_KEY  = '0,
  parameter logic [DATA_W-1:0] PRE_DATA = '0,
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [KEY_W-1:0]              i_key,
  output logic                          o_hit,
  output logic [IDX_W-1:0]              o_hit_idx,
  output logic [IDX_W-1:0]              o_free_idx,
  output logic                          o_full,
  output logic [DEPTH-1:0][DATA_W-1:0]  o_data,
  input  logic                          i_wr,
  input  logic [IDX_W-1:0]              i_wr_idx,
  input  logic [KEY_W-1:0]              i_wr_key,
  input  logic [DATA_W-1:0]             i_wr_data,
  input  logic                          i_clr,
  input  logic [IDX_W-1:0]              i_clr_idx
);

  logic [DEPTH-1:0]             r_valid;
  logic [DEPTH-1:0][KEY_W-1:0]  r_key;
  logic [DEPTH-1:0][DATA_W-1:0] r_data;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid <= '0;
      r_key   <= '0;
      r_data  <= '0;
      if (PRELOAD) begin
        r_valid[0] <= 1'b1;
        r_key[0]   <= PRE_KEY;
        r_data[0]  <= PRE_DATA;
      end
    end else begin
      if (i_clr) r_valid[i_clr_idx] <= 1'b0;
      if (i_wr) begin
        r_valid[i_wr_idx] <= 1'b1;
        r_key[i_wr_idx]   <= i_wr_key;
        r_data[i_wr_idx]  <= i_wr_data;
      end
    end
  end

  // A zero key never matches, so empty/zero tokens cannot alias a slot.
  always_comb begin
    o_hit      = 1'b0;
    o_hit_idx  = '0;
    o_free_idx = '0;
    o_full     = 1'b1;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!o_hit && r_valid[i] && (r_key[i] == i_key) && (i_key != '0)) begin
        o_hit     = 1'b1;
        o_hit_idx = IDX_W'(i);
      end
      if (o_full && !r_valid[i]) begin
        o_full     = 1'b0;
        o_free_idx = IDX_W'(i);
      end
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/shop_ctrl.sv
// shop_ctrl: shop command FSM; owns login, permission and stock state.
//   i_clk, i_reset - clock, asynchronous active-high reset
//   bus (slave)    - i_rdy/i_tok token input, o_msg/o_msg_vld response,
//                    o_user/o_logged_in session status
// One response per accepted token, registered on the accepting edge.
module shop_ctrl
  import shop_pkg::*;
#(
  parameter int unsigned TOK_W     = 72,
  parameter int unsigned MAX_USERS = 4,
  parameter int unsigned MAX_ITEMS = 8,
  parameter int unsigned STOCK_W   = 8,
  parameter logic [TOK_W-1:0] ADMIN_NAME = TOK_W'("Adm"),
  parameter logic [TOK_W-1:0] ADMIN_PW   = TOK_W'("Pw0")
) (
  input  logic   i_clk,
  input  logic   i_reset,
  shop_if.slave  bus
);

  localparam int unsigned UW  = $clog2(MAX_USERS);
  localparam int unsigned IW  = $clog2(MAX_ITEMS);
  localparam int unsigned UDW = TOK_W + 1;

  state_t             r_state, w_state;
  cmd_t               r_cmd, w_cmd_lat, w_cmd;
  logic [UW-1:0]      r_uidx, w_uidx;
  logic [IW-1:0]      r_iidx, w_iidx;
  logic               r_item_new, w_item_new;
  logic [TOK_W-1:0]   r_name, w_name;
  logic [TOK_W-1:0]   r_pw, w_pw;
  logic [TOK_W-1:0]   r_msg, w_msg;
  logic               r_msg_vld;
  logic [UW-1:0]      r_user, w_user;
  logic               r_logged_in, w_logged_in;

  logic                           w_u_hit, w_u_full, w_u_wr, w_u_clr;
  logic [UW-1:0]                  w_u_hit_idx, w_u_free_idx, w_u_clr_idx;
  logic [MAX_USERS-1:0][UDW-1:0]  w_u_data;
  logic [UDW-1:0]                 w_u_wr_data;

  logic                              w_i_hit, w_i_full, w_i_wr, w_i_clr;
  logic [IW-1:0]                     w_i_hit_idx, w_i_free_idx, w_i_clr_idx;
  logic [MAX_ITEMS-1:0][STOCK_W-1:0] w_i_data;
  logic [STOCK_W-1:0]                w_i_wr_data;

  logic [STOCK_W-1:0] w_stock, w_qty, w_sat;
  logic [STOCK_W:0]   w_sum;
  logic               w_is_admin, w_tok_zero;

  shop_table #(
    .DEPTH(MAX_USERS), .KEY_W(TOK_W), .DATA_W(UDW), .PRELOAD(1'b1),
    .PRE_KEY(ADMIN_NAME), .PRE_DATA({ADMIN_PW, PERM_ADMIN})
  ) u_users (
    .i_clk(i_clk), .i_reset(i_reset), .i_key(bus.i_tok),
    .o_hit(w_u_hit), .o_hit_idx(w_u_hit_idx), .o_free_idx(w_u_free_idx),
    .o_full(w_u_full), .o_data(w_u_data),
    .i_wr(w_u_wr), .i_wr_idx(w_u_free_idx), .i_wr_key(r_name), .i_wr_data(w_u_wr_data),
    .i_clr(w_u_clr), .i_clr_idx(w_u_clr_idx)
  );

  shop_table #(
    .DEPTH(MAX_ITEMS), .KEY_W(TOK_W), .DATA_W(STOCK_W), .PRELOAD(1'b0),
    .PRE_KEY('0), .PRE_DATA('0)
  ) u_items (
    .i_clk(i_clk), .i_reset(i_reset), .i_key(bus.i_tok),
    .o_hit(w_i_hit), .o_hit_idx(w_i_hit_idx), .o_free_idx(w_i_free_idx),
    .o_full(w_i_full), .o_data(w_i_data),
    .i_wr(w_i_wr), .i_wr_idx(r_iidx), .i_wr_key(r_name), .i_wr_data(w_i_wr_data),
    .i_clr(w_i_clr), .i_clr_idx(w_i_clr_idx)
  );

  // Upper bits beyond the packed-string width must be zero for a command match.
  assign w_cmd = (bus.i_tok == TOK_W'(str_t'(bus.i_tok))) ? decode_cmd(str_t'(bus.i_tok)) : C_NONE;
  assign w_tok_zero = (bus.i_tok == '0);
  assign w_is_admin = r_logged_in && (w_u_data[r_user][0] == PERM_ADMIN);

  // New items count from zero; AddItem saturates at the stock ceiling.
  assign w_stock = r_item_new ? '0 : w_i_data[r_iidx];
  assign w_qty   = bus.i_tok[STOCK_W-1:0];
  assign w_sum   = {1'b0, w_stock} + {1'b0, w_qty};
  assign w_sat   = w_sum[STOCK_W] ? '1 : w_sum[STOCK_W-1:0];

  always_comb begin
    w_state     = r_state;
    w_cmd_lat   = r_cmd;
    w_uidx      = r_uidx;
    w_iidx      = r_iidx;
    w_item_new  = r_item_new;
    w_name      = r_name;
    w_pw        = r_pw;
    w_msg       = r_msg;
    w_user      = r_user;
    w_logged_in = r_logged_in;
    w_u_wr      = 1'b0;
    w_u_wr_data = {r_pw, PERM_BUYER};
    w_u_clr     = 1'b0;
    w_u_clr_idx = w_u_hit_idx;
    w_i_wr      = 1'b0;
    w_i_wr_data = w_sat;
    w_i_clr     = 1'b0;
    w_i_clr_idx = w_i_hit_idx;

    if (bus.i_rdy) begin
      w_state = S_CMD;
      unique case (r_state)
        S_CMD: begin
          w_cmd_lat = w_cmd;
          w_state   = S_CMD;
          unique case (w_cmd)
            C_NONE:  w_msg = TOK_W'(RSP_INVALCMD);
            C_LOGIN: begin
              w_state = S_USER;
              w_msg   = TOK_W'(RSP_USRNAME);
            end
            C_LOGOUT: begin
              if (r_logged_in) begin
                w_logged_in = 1'b0;
                w_user      = '0;
                w_msg       = TOK_W'(RSP_OK);
              end else begin
                w_msg = TOK_W'(RSP_INVALPERM);
              end
            end
            C_BUY: begin
              if (r_logged_in) begin
                w_state = S_ITEM;
                w_msg   = TOK_W'(RSP_ITEM);
              end else begin
                w_msg = TOK_W'(RSP_INVALPERM);
              end
            end
            default: begin
              if (!w_is_admin) begin
                w_msg = TOK_W'(RSP_INVALPERM);
              end else if (w_cmd == C_ADDUSR || w_cmd == C_DELUSR) begin
                w_state = S_USER;
                w_msg   = TOK_W'(RSP_USRNAME);
              end else begin
                w_state = S_ITEM;
                w_msg   = TOK_W'(RSP_ITEM);
              end
            end
          endcase
        end

        S_USER: begin
          w_name = bus.i_tok;
          unique case (r_cmd)
            C_LOGIN: begin
              if (w_u_hit) begin
                w_uidx  = w_u_hit_idx;
                w_state = S_PASS;
                w_msg   = TOK_W'(RSP_PASSWD);
              end else begin
                w_msg = TOK_W'(RSP_USRUNKNWN);
              end
            end
            C_ADDUSR: begin
              if (w_tok_zero)    w_msg = TOK_W'(RSP_USRUNKNWN);
              else if (w_u_hit)  w_msg = TOK_W'(RSP_USRTAKEN);
              else if (w_u_full) w_msg = TOK_W'(RSP_FULL);
              else begin
                w_state = S_PASS;
                w_msg   = TOK_W'(RSP_PASSWD);
              end
            end
            C_DELUSR: begin
              if (bus.i_tok == ADMIN_NAME) w_msg = TOK_W'(RSP_NODELADMN);
              else if (!w_u_hit)           w_msg = TOK_W'(RSP_USRUNKNWN);
              else begin
                w_u_clr = 1'b1;
                w_msg   = TOK_W'(RSP_OK);
                if (r_logged_in && r_user == w_u_hit_idx) begin
                  w_logged_in = 1'b0;
                  w_user      = '0;
                end
              end
            end
            default: w_msg = TOK_W'(RSP_INVALCMD);
          endcase
        end

        S_PASS: begin
          if (r_cmd == C_ADDUSR) begin
            w_pw    = bus.i_tok;
            w_state = S_PERM;
            w_msg   = TOK_W'(RSP_PERM);
          end else if (bus.i_tok == w_u_data[r_uidx][UDW-1:1]) begin
            w_logged_in = 1'b1;
            w_user      = r_uidx;
            w_msg       = TOK_W'(RSP_OK);
          end else begin
            w_msg = TOK_W'(RSP_BADPASS);
          end
        end

        S_PERM: begin
          w_u_wr      = 1'b1;
          w_u_wr_data = {r_pw, (bus.i_tok == TOK_W'(TOK_PERM_ADMIN)) ? PERM_ADMIN : PERM_BUYER};
          w_msg       = TOK_W'(RSP_OK);
        end

        S_ITEM: begin
          w_name = bus.i_tok;
          if (r_cmd == C_ADDITEM) begin
            if (w_tok_zero) begin
              w_msg = TOK_W'(RSP_ITMUNKNWN);
            end else if (w_i_hit || !w_i_full) begin
              w_iidx     = w_i_hit ? w_i_hit_idx : w_i_free_idx;
              w_item_new = !w_i_hit;
              w_state    = S_QTY;
              w_msg      = TOK_W'(RSP_QTY);
            end else begin
              w_msg = TOK_W'(RSP_FULL);
            end
          end else if (!w_i_hit) begin
            w_msg = TOK_W'(RSP_ITMUNKNWN);
          end else if (r_cmd == C_DELITEM) begin
            w_i_clr = 1'b1;
            w_msg   = TOK_W'(RSP_OK);
          end else begin
            w_iidx     = w_i_hit_idx;
            w_item_new = 1'b0;
            w_state    = S_QTY;
            w_msg      = TOK_W'(RSP_QTY);
          end
        end

        S_QTY: begin
          w_msg = TOK_W'(RSP_OK);
          if (r_cmd == C_ADDITEM) begin
            w_i_wr = 1'b1;
          end else if (w_qty > w_stock) begin
            w_msg = TOK_W'(RSP_NOSTOCK);
          end else if (w_qty != '0) begin
            w_i_wr      = 1'b1;
            w_i_wr_data = w_stock - w_qty;
          end
        end

        default: w_state = S_CMD;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_CMD;
      r_cmd       <= C_NONE;
      r_uidx      <= '0;
      r_iidx      <= '0;
      r_item_new  <= 1'b0;
      r_name      <= '0;
      r_pw        <= '0;
      r_msg       <= TOK_W'(RSP_CMD);
      r_msg_vld   <= 1'b0;
      r_user      <= '0;
      r_logged_in <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cmd       <= w_cmd_lat;
      r_uidx      <= w_uidx;
      r_iidx      <= w_iidx;
      r_item_new  <= w_item_new;
      r_name      <= w_name;
      r_pw        <= w_pw;
      r_msg       <= w_msg;
      r_msg_vld   <= bus.i_rdy;
      r_user      <= w_user;
      r_logged_in <= w_logged_in;
    end
  end

  assign bus.o_msg       = r_msg;
  assign bus.o_msg_vld   = r_msg_vld;
  assign bus.o_user      = r_user;
  assign bus.o_logged_in = r_logged_in;

endmodule

// File: tb/tb_shop_ctrl.sv
// tb_shop_ctrl: directed scoreboard bench for shop_ctrl.
module tb_shop_ctrl;

  typedef logic [71:0] tok_t;
  `define T(s) tok_t'(s)

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shop_if #(.TOK_W(72), .USER_W(2)) bus ();

  shop_ctrl #(
    .TOK_W(72), .MAX_USERS(4), .MAX_ITEMS(8), .STOCK_W(8)
  ) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  tok_t exp_q[$];
  tok_t last_rsp;

  task automatic chk_msg(input string tag, input tok_t obs, input tok_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed \"%s\" (%h) expected \"%s\"", tag, obs, obs, exp);
    end
  endtask

  task automatic chk_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one token; the response is due on the same accepting edge.
  task automatic send(input string tag, input tok_t tok, input tok_t rsp);
    @(negedge clk);
    bus.i_rdy = 1'b1;
    bus.i_tok = tok;
    exp_q.push_back(rsp);
    @(posedge clk);
    #1;
    bus.i_rdy = 1'b0;
    last_rsp  = exp_q.pop_front();
    chk_val({tag, ".vld"}, 8'(bus.o_msg_vld), 8'd1);
    chk_msg(tag, bus.o_msg, last_rsp);
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk_val({tag, ".vld"}, 8'(bus.o_msg_vld), 8'd0);
    chk_msg({tag, ".hold"}, bus.o_msg, last_rsp);
  endtask

  task automatic session(input string tag, input logic li, input logic [1:0] u);
    chk_val({tag, ".li"}, 8'(bus.o_logged_in), 8'(li));
    if (li) chk_val({tag, ".user"}, 8'(bus.o_user), 8'(u));
  endtask

  task automatic login(input string tag, input tok_t nm, input tok_t pw, input tok_t rsp);
    send({tag, ".cmd"}, `T("Login"), `T("Usrname?"));
    send({tag, ".name"}, nm, `T("Passwd?"));
    send({tag, ".pw"}, pw, rsp);
  endtask

  task automatic add_usr(input string tag, input tok_t nm, input tok_t pw, input tok_t perm);
    send({tag, ".cmd"}, `T("AddUsr"), `T("Usrname?"));
    send({tag, ".name"}, nm, `T("Passwd?"));
    send({tag, ".pw"}, pw, `T("Perm?"));
    send({tag, ".perm"}, perm, `T("OK"));
  endtask

  task automatic item_op(input string tag, input tok_t cmd, input tok_t nm, input int qty, input tok_t rsp);
    send({tag, ".cmd"}, cmd, `T("Item?"));
    send({tag, ".item"}, nm, `T("Qty?"));
    send({tag, ".qty"}, tok_t'(qty), rsp);
  endtask

  initial begin
    tok_t nm;
    rst       = 1'b1;
    bus.i_rdy = 1'b0;
    bus.i_tok = '0;
    #2;
    chk_msg("reset.msg", bus.o_msg, `T("Cmd?"));
    chk_val("reset.vld", 8'(bus.o_msg_vld), 8'd0);
    chk_val("reset.li", 8'(bus.o_logged_in), 8'd0);
    chk_val("reset.user", 8'(bus.o_user), 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst      = 1'b0;
    last_rsp = `T("Cmd?");

    send("pre.additem", `T("AddItem"), `T("InvalPerm"));
    send("pre.logout", `T("Logout"), `T("InvalPerm"));
    send("pre.unknown", `T("Foo"), `T("InvalCmd"));
    idle_check("idle");

    login("adm", `T("Adm"), `T("Pw0"), `T("OK"));
    session("adm", 1'b1, 2'd0);

    add_usr("bob", `T("Bob"), `T("x1"), `T("B"));
    send("bob2.cmd", `T("AddUsr"), `T("Usrname?"));
    send("bob2.name", `T("Bob"), `T("UsrTaken"));
    send("deladm.cmd", `T("DelUsr"), `T("Usrname?"));
    send("deladm.name", `T("Adm"), `T("NoDelAdmn"));

    item_op("pen250", `T("AddItem"), `T("Pen"), 250, `T("OK"));
    item_op("pen10", `T("AddItem"), `T("Pen"), 10, `T("OK"));

    send("logout1", `T("Logout"), `T("OK"));
    session("logout1", 1'b0, 2'd0);
    login("bobbad", `T("Bob"), `T("zz"), `T("BadPass"));
    session("bobbad", 1'b0, 2'd0);
    login("bob", `T("Bob"), `T("x1"), `T("OK"));
    session("bob", 1'b1, 2'd1);

    send("bob.additem", `T("AddItem"), `T("InvalPerm"));
    send("bob.stay", `T("Pen"), `T("InvalCmd"));

    // Stock 255 only if the add saturated; a wrap would leave 4.
    item_op("buy5", `T("Buy"), `T("Pen"), 5, `T("OK"));
    item_op("buy251", `T("Buy"), `T("Pen"), 251, `T("NoStock"));
    send("buycup.cmd", `T("Buy"), `T("Item?"));
    send("buycup.item", `T("Cup"), `T("ItmUnknwn"));
    item_op("buy250", `T("Buy"), `T("Pen"), 250, `T("OK"));
    item_op("buy1", `T("Buy"), `T("Pen"), 1, `T("NoStock"));
    item_op("buy0", `T("Buy"), `T("Pen"), 0, `T("OK"));

    send("logout2", `T("Logout"), `T("OK"));
    login("adm2", `T("Adm"), `T("Pw0"), `T("OK"));
    for (int i = 1; i <= 7; i++) begin
      nm = `T("I0") + tok_t'(i);
      item_op("fill", `T("AddItem"), nm, 1, `T("OK"));
    end
    send("full.cmd", `T("AddItem"), `T("Item?"));
    send("full.item", `T("New"), `T("Full"));
    item_op("fullexist", `T("AddItem"), `T("I3"), 5, `T("OK"));
    send("delcup.cmd", `T("DelItem"), `T("Item?"));
    send("delcup.item", `T("Cup"), `T("ItmUnknwn"));
    send("deli1.cmd", `T("DelItem"), `T("Item?"));
    send("deli1.item", `T("I1"), `T("OK"));
    item_op("addnew", `T("AddItem"), `T("New"), 7, `T("OK"));

    add_usr("cat", `T("Cat"), `T("c"), `T("A"));
    add_usr("dan", `T("Dan"), `T("d"), `T("B"));
    send("eve.cmd", `T("AddUsr"), `T("Usrname?"));
    send("eve.name", `T("Eve"), `T("Full"));

    send("logout3", `T("Logout"), `T("OK"));
    login("cat", `T("Cat"), `T("c"), `T("OK"));
    session("cat", 1'b1, 2'd2);
    send("delself.cmd", `T("DelUsr"), `T("Usrname?"));
    send("delself.name", `T("Cat"), `T("OK"));
    session("delself", 1'b0, 2'd0);
    send("catgone.cmd", `T("Login"), `T("Usrname?"));
    send("catgone.name", `T("Cat"), `T("UsrUnknwn"));

    login("adm3", `T("Adm"), `T("Pw0"), `T("OK"));
    send("midrst.cmd", `T("Login"), `T("Usrname?"));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_msg("midrst.msg", bus.o_msg, `T("Cmd?"));
    chk_val("midrst.vld", 8'(bus.o_msg_vld), 8'd0);
    chk_val("midrst.li", 8'(bus.o_logged_in), 8'd0);
    chk_val("midrst.user", 8'(bus.o_user), 8'd0);
    @(negedge clk);
    rst      = 1'b0;
    last_rsp = `T("Cmd?");
    idle_check("postrst");
    send("postrst.pw", `T("Pw0"), `T("InvalCmd"));
    send("postrst.buy", `T("Buy"), `T("InvalPerm"));
    send("postrst.bob.cmd", `T("Login"), `T("Usrname?"));
    send("postrst.bob.name", `T("Bob"), `T("UsrUnknwn"));
    login("postrst.adm", `T("Adm"), `T("Pw0"), `T("OK"));
    send("postrst.pen.cmd", `T("Buy"), `T("Item?"));
    send("postrst.pen.item", `T("Pen"), `T("ItmUnknwn"));

    chk_val("queue.empty", 8'(exp_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
